// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage.
// Decodes instruction + PC into a full control bundle and buffers the result in a
// DEPTH-entry FIFO so fetch never sees combinational backpressure from execute.
// Optional RV32M decode is compiled in when DECODE_STAGE_RV32M_EN is defined; otherwise
// funct7 = 0000001 R-type encodings are illegal and o_out_muldiv is tied to 0.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_instr,
  input  logic [XLEN-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out_pc,
  output logic [XLEN-1:0] o_out_imm,
  output logic [4:0]      o_out_rs1,
  output logic [4:0]      o_out_rs2,
  output logic [4:0]      o_out_rd,
  output logic [2:0]      o_out_funct3,
  output logic [3:0]      o_out_alu_ctrl,
  output logic            o_out_alu_src,
  output logic [1:0]      o_out_alu_a_sel,
  output logic            o_out_branch,
  output logic            o_out_jal,
  output logic            o_out_jalr,
  output logic            o_out_mem_rd,
  output logic            o_out_mem_wr,
  output logic            o_out_mem_to_reg,
  output logic            o_out_reg_wr,
  output logic            o_out_illegal,
  output logic            o_out_muldiv
);

  // Elaboration-time parameter checks
  if (XLEN != 32) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("decode_stage: DEPTH must be a power of two >= 2");
  end

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [1:0] ASelRs1  = 2'b00;
  localparam logic [1:0] ASelPc   = 2'b01;
  localparam logic [1:0] ASelZero = 2'b10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_ctrl;
    logic            alu_src;
    logic [1:0]      alu_a_sel;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            mem_rd;
    logic            mem_wr;
    logic            mem_to_reg;
    logic            reg_wr;
    logic            illegal;
  } bundle_t;

  // Instruction fields
  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;

  assign w_opcode = i_in_instr[6:0];
  assign w_funct3 = i_in_instr[14:12];
  assign w_funct7 = i_in_instr[31:25];

  assign w_imm_i = {{(XLEN-12){i_in_instr[31]}}, i_in_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){i_in_instr[31]}}, i_in_instr[31:25], i_in_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){i_in_instr[31]}}, i_in_instr[31], i_in_instr[7],
                    i_in_instr[30:25], i_in_instr[11:8], 1'b0};
  assign w_imm_u = {i_in_instr[31:12], 12'b0};
  assign w_imm_j = {{(XLEN-21){i_in_instr[31]}}, i_in_instr[31], i_in_instr[19:12],
                    i_in_instr[20], i_in_instr[30:21], 1'b0};

  bundle_t w_dec;
  logic    w_bad;
`ifdef DECODE_STAGE_RV32M_EN
  logic    w_muldiv;
`endif

  // Combinational decode of the incoming instruction into a control bundle
  always_comb begin
    w_dec        = '0;
    w_bad        = 1'b0;
`ifdef DECODE_STAGE_RV32M_EN
    w_muldiv     = 1'b0;
`endif
    w_dec.pc     = i_in_pc;
    w_dec.rs1    = i_in_instr[19:15];
    w_dec.rs2    = i_in_instr[24:20];
    w_dec.rd     = i_in_instr[11:7];
    w_dec.funct3 = w_funct3;

    case (w_opcode)
      OpReg: begin
        w_dec.reg_wr = 1'b1;
        if (w_funct7 == 7'b0000000) begin
          w_dec.alu_ctrl = {1'b0, w_funct3};
        end else if ((w_funct7 == 7'b0100000) &&
                     ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
          w_dec.alu_ctrl = {1'b1, w_funct3};
        end else if (w_funct7 == 7'b0000001) begin
`ifdef DECODE_STAGE_RV32M_EN
          w_dec.alu_ctrl = {1'b0, w_funct3};
          w_muldiv       = 1'b1;
`else
          w_bad = 1'b1;
`endif
        end else begin
          w_bad = 1'b1;
        end
      end
      OpImm: begin
        w_dec.reg_wr  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.imm     = w_imm_i;
        // Only SRAI carries instr[30] into the ALU op; other I-ops use it as imm bits
        if (w_funct3 == 3'b101) begin
          w_dec.alu_ctrl = {i_in_instr[30], w_funct3};
          if ((w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000)) begin
            w_bad = 1'b1;
          end
        end else begin
          w_dec.alu_ctrl = {1'b0, w_funct3};
          if ((w_funct3 == 3'b001) && (w_funct7 != 7'b0000000)) begin
            w_bad = 1'b1;
          end
        end
      end
      OpLoad: begin
        w_dec.mem_rd     = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_wr     = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.imm        = w_imm_i;
        if ((w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111)) begin
          w_bad = 1'b1;
        end
      end
      OpStore: begin
        w_dec.mem_wr  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.imm     = w_imm_s;
        if (w_funct3 > 3'b010) begin
          w_bad = 1'b1;
        end
      end
      OpBranch: begin
        w_dec.branch = 1'b1;
        w_dec.imm    = w_imm_b;
        case (w_funct3)
          3'b000, 3'b001: w_dec.alu_ctrl = 4'b1000;
          3'b100, 3'b101: w_dec.alu_ctrl = 4'b0010;
          3'b110, 3'b111: w_dec.alu_ctrl = 4'b0011;
          default:        w_bad          = 1'b1;
        endcase
      end
      OpJal: begin
        w_dec.jal       = 1'b1;
        w_dec.reg_wr    = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_a_sel = ASelPc;
        w_dec.imm       = w_imm_j;
      end
      OpJalr: begin
        w_dec.jalr    = 1'b1;
        w_dec.reg_wr  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_dec.imm     = w_imm_i;
        if (w_funct3 != 3'b000) begin
          w_bad = 1'b1;
        end
      end
      OpLui: begin
        w_dec.reg_wr    = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_a_sel = ASelZero;
        w_dec.imm       = w_imm_u;
      end
      OpAuipc: begin
        w_dec.reg_wr    = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_a_sel = ASelPc;
        w_dec.imm       = w_imm_u;
      end
      // Also catches every word whose low two bits are not 11
      default: w_bad = 1'b1;
    endcase

    // Illegal entries still flow down the pipe but must not cause side effects
    if (w_bad) begin
      w_dec.reg_wr     = 1'b0;
      w_dec.mem_rd     = 1'b0;
      w_dec.mem_wr     = 1'b0;
      w_dec.mem_to_reg = 1'b0;
      w_dec.branch     = 1'b0;
      w_dec.jal        = 1'b0;
      w_dec.jalr       = 1'b0;
    end
    w_dec.illegal = w_bad;
    if (w_dec.rd == 5'd0) begin
      w_dec.reg_wr = 1'b0;
    end
  end

  // Output queue state
  bundle_t        r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;

  assign o_in_ready  = (r_count != CW'(DEPTH));
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid && o_in_ready && !i_flush;
  assign w_pop       = o_out_valid && i_out_ready && !i_flush;

  // Pointer and occupancy tracking; flush wins over push and pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Bundle storage; cleared on reset so head outputs read zero while empty
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_dec;
    end
  end

  bundle_t w_head;
  assign w_head = r_mem[r_rd_ptr];

  assign o_out_pc         = w_head.pc;
  assign o_out_imm        = w_head.imm;
  assign o_out_rs1        = w_head.rs1;
  assign o_out_rs2        = w_head.rs2;
  assign o_out_rd         = w_head.rd;
  assign o_out_funct3     = w_head.funct3;
  assign o_out_alu_ctrl   = w_head.alu_ctrl;
  assign o_out_alu_src    = w_head.alu_src;
  assign o_out_alu_a_sel  = w_head.alu_a_sel;
  assign o_out_branch     = w_head.branch;
  assign o_out_jal        = w_head.jal;
  assign o_out_jalr       = w_head.jalr;
  assign o_out_mem_rd     = w_head.mem_rd;
  assign o_out_mem_wr     = w_head.mem_wr;
  assign o_out_mem_to_reg = w_head.mem_to_reg;
  assign o_out_reg_wr     = w_head.reg_wr;
  assign o_out_illegal    = w_head.illegal;

`ifdef DECODE_STAGE_RV32M_EN
  logic [DEPTH-1:0] r_muldiv;

  // Muldiv flag storage, kept parallel to the bundle queue
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_muldiv <= '0;
    end else if (w_push) begin
      r_muldiv[r_wr_ptr] <= w_muldiv;
    end
  end

  assign o_out_muldiv = r_muldiv[r_rd_ptr];
`else
  assign o_out_muldiv = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage.
// The driver issues stimulus and pushes expected bundles from a reference decoder;
// a separate negedge monitor compares the DUT head entry and pops on retirement.
module tb_decode_stage;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_ctrl;
  logic        out_alu_src;
  logic [1:0]  out_alu_a_sel;
  logic        out_branch, out_jal, out_jalr, out_mem_rd, out_mem_wr, out_mem_to_reg;
  logic        out_reg_wr, out_illegal, out_muldiv;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_instr(in_instr), .i_in_pc(in_pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_pc(out_pc), .o_out_imm(out_imm),
    .o_out_rs1(out_rs1), .o_out_rs2(out_rs2), .o_out_rd(out_rd), .o_out_funct3(out_funct3),
    .o_out_alu_ctrl(out_alu_ctrl), .o_out_alu_src(out_alu_src),
    .o_out_alu_a_sel(out_alu_a_sel),
    .o_out_branch(out_branch), .o_out_jal(out_jal), .o_out_jalr(out_jalr),
    .o_out_mem_rd(out_mem_rd), .o_out_mem_wr(out_mem_wr), .o_out_mem_to_reg(out_mem_to_reg),
    .o_out_reg_wr(out_reg_wr), .o_out_illegal(out_illegal), .o_out_muldiv(out_muldiv)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        src;
    logic [1:0]  asel;
    logic        br, jal, jalr, mrd, mwr, m2r, rwr, ill, md;
  } exp_t;

  exp_t exp_q[$];
  int   m_count;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder written straight from the ISA rules, using value arithmetic
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t       e;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int         ii, is, ib, ij;
    logic       legal;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
    is = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
    ib = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}) - (ins[31] ? 8192 : 0);
    ij = int'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}) - (ins[31] ? 2097152 : 0);
    e = '0;
    e.pc  = pc;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = f3;
    legal = 1'b1;
    case (op)
      7'b0110011: begin
        e.rwr = 1'b1;
        if (f7 == 7'h00) e.alu = {1'b0, f3};
        else if (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) e.alu = {1'b1, f3};
`ifdef DECODE_STAGE_RV32M_EN
        else if (f7 == 7'h01) begin e.alu = {1'b0, f3}; e.md = 1'b1; end
`endif
        else legal = 1'b0;
      end
      7'b0010011: begin
        e.rwr = 1'b1; e.src = 1'b1; e.imm = 32'(ii);
        e.alu = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
        if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
        if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) legal = 1'b0;
      end
      7'b0000011: begin
        e.mrd = 1'b1; e.m2r = 1'b1; e.rwr = 1'b1; e.src = 1'b1; e.imm = 32'(ii);
        legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'b0100011: begin
        e.mwr = 1'b1; e.src = 1'b1; e.imm = 32'(is);
        legal = (f3 <= 3'd2);
      end
      7'b1100011: begin
        e.br = 1'b1; e.imm = 32'(ib);
        if (f3 <= 3'd1) e.alu = 4'h8;
        else if (f3 inside {3'd4, 3'd5}) e.alu = 4'h2;
        else if (f3 >= 3'd6) e.alu = 4'h3;
        else legal = 1'b0;
      end
      7'b1101111: begin
        e.jal = 1'b1; e.rwr = 1'b1; e.src = 1'b1; e.asel = 2'b01; e.imm = 32'(ij);
      end
      7'b1100111: begin
        e.jalr = 1'b1; e.rwr = 1'b1; e.src = 1'b1; e.imm = 32'(ii);
        legal = (f3 == 3'd0);
      end
      7'b0110111: begin
        e.rwr = 1'b1; e.src = 1'b1; e.asel = 2'b10; e.imm = ins & 32'hFFFF_F000;
      end
      7'b0010111: begin
        e.rwr = 1'b1; e.src = 1'b1; e.asel = 2'b01; e.imm = ins & 32'hFFFF_F000;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.ill = 1'b1;
      {e.rwr, e.mrd, e.mwr, e.m2r, e.br, e.jal, e.jalr, e.md} = '0;
    end
    if (e.rd == 5'd0) e.rwr = 1'b0;
    return e;
  endfunction

  task automatic check_head(input exp_t e);
    chk("pc", out_pc, e.pc);
    chk("rs1", 32'(out_rs1), 32'(e.rs1));
    chk("rs2", 32'(out_rs2), 32'(e.rs2));
    chk("rd", 32'(out_rd), 32'(e.rd));
    chk("funct3", 32'(out_funct3), 32'(e.f3));
    chk("illegal", 32'(out_illegal), 32'(e.ill));
    chk("reg_wr", 32'(out_reg_wr), 32'(e.rwr));
    chk("mem_rd", 32'(out_mem_rd), 32'(e.mrd));
    chk("mem_wr", 32'(out_mem_wr), 32'(e.mwr));
    chk("mem_to_reg", 32'(out_mem_to_reg), 32'(e.m2r));
    chk("branch", 32'(out_branch), 32'(e.br));
    chk("jal", 32'(out_jal), 32'(e.jal));
    chk("jalr", 32'(out_jalr), 32'(e.jalr));
    chk("muldiv", 32'(out_muldiv), 32'(e.md));
    if (!e.ill) begin
      chk("imm", out_imm, e.imm);
      chk("alu_ctrl", 32'(out_alu_ctrl), 32'(e.alu));
      chk("alu_src", 32'(out_alu_src), 32'(e.src));
      chk("alu_a_sel", 32'(out_alu_a_sel), 32'(e.asel));
    end
  endtask

  // Monitor: occupancy flags against the model count, head contents against the scoreboard
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_count != 0));
    chk("in_ready", 32'(in_ready), 32'(m_count != DEPTH));
    if (m_count != 0) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 32'(exp_q.size()), 32'(m_count));
      end else begin
        check_head(exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of stimulus; the model advances at the edge using only its own state
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic push, pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    push = v && (m_count != DEPTH) && !fl;
    pop  = (m_count != 0) && rdy;
    if (fl) begin
      m_count = 0;
      exp_q.delete();
    end else begin
      m_count = m_count + int'(push) - int'(pop);
      if (push) exp_q.push_back(ref_decode(ins, pc));
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset_check();
    in_valid = 1'b0;
    flush    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    chk("arst_out_pc", out_pc, 32'h0);
    chk("arst_out_imm", out_imm, 32'h0);
    chk("arst_out_rd", 32'(out_rd), 32'h0);
    chk("arst_out_mem_rd", 32'(out_mem_rd), 32'h0);
    m_count = 0;
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case ($urandom_range(0, 10))
      0:       op = 7'b0110011;
      1:       op = 7'b0010011;
      2:       op = 7'b0000011;
      3:       op = 7'b0100011;
      4:       op = 7'b1100011;
      5:       op = 7'b1101111;
      6:       op = 7'b1100111;
      7:       op = 7'b0110111;
      8:       op = 7'b0010111;
      9:       op = {w[6:2], 2'b11};
      default: op = w[6:0];
    endcase
    w[6:0] = op;
    if (op == 7'b0110011 || (op == 7'b0010011 && w[13:12] == 2'b01)) begin
      case ($urandom_range(0, 3))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        2:       w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    m_count   = 0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 32'h0;
    out_ready = 1'b0;
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_alu_ctrl", 32'(out_alu_ctrl), 32'h0);
    chk("rst_out_reg_wr", 32'(out_reg_wr), 32'h0);
    chk("rst_out_illegal", 32'(out_illegal), 32'h0);
    chk("rst_out_muldiv", 32'(out_muldiv), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi x1,x0,-1
    cycle(1'b1, 32'hFFF0_0093, 32'h0000_0000, 1'b0, 1'b0);
    chk("addi_valid", 32'(out_valid), 32'h1);
    chk("addi_imm", out_imm, 32'hFFFF_FFFF);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // sub then lw with execute stalled; queue must report full
    cycle(1'b1, 32'h4020_81B3, 32'h0000_0004, 1'b0, 1'b0);
    cycle(1'b1, 32'h0081_2283, 32'h0000_0008, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("sub_alu_ctrl", 32'(out_alu_ctrl), 32'h8);
    cycle(1'b1, 32'h0000_0013, 32'h0000_000C, 1'b1, 1'b0);
    chk("pop_in_ready", 32'(in_ready), 32'h1);
    chk("lw_imm", out_imm, 32'h0000_0008);
    idle(3);

    // beq x1,x2,-4 at 0x100
    cycle(1'b1, 32'hFE20_8EE3, 32'h0000_0100, 1'b1, 1'b0);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    idle(1);

    // Illegal words
    cycle(1'b1, 32'h0000_007F, 32'h0000_0200, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0000, 32'h0000_0204, 1'b1, 1'b0);
    idle(2);

    // Flush a full queue with a concurrent push, then a partial queue
    cycle(1'b1, 32'h0010_0093, 32'h0000_0300, 1'b0, 1'b0);
    cycle(1'b1, 32'h0020_0113, 32'h0000_0304, 1'b0, 1'b0);
    cycle(1'b1, 32'h0030_0193, 32'h0000_0308, 1'b0, 1'b1);
    chk("flush_full_valid", 32'(out_valid), 32'h0);
    cycle(1'b1, 32'h0040_0213, 32'h0000_0310, 1'b0, 1'b0);
    cycle(1'b1, 32'h0050_0293, 32'h0000_0314, 1'b0, 1'b1);
    chk("flush_part_valid", 32'(out_valid), 32'h0);
    cycle(1'b1, 32'h0060_0313, 32'h0000_0318, 1'b1, 1'b0);
    chk("post_flush_pc", out_pc, 32'h0000_0318);
    idle(1);

    // Mid-stream asynchronous reset
    cycle(1'b1, 32'h0070_0393, 32'h0000_0400, 1'b0, 1'b0);
    cycle(1'b1, 32'h0080_0413, 32'h0000_0404, 1'b0, 1'b0);
    async_reset_check();

    // mul x1,x2,x3
    cycle(1'b1, 32'h0231_00B3, 32'h0000_0500, 1'b1, 1'b0);
    idle(1);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
      if (k == 400) async_reset_check();
    end
    idle(DEPTH + 2);
    chk("drain_scoreboard", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
